// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file for the pipelined core.
// It has NRD combinational read ports, NWR prioritised write ports (the highest
// port index wins), optional same-cycle write-to-read bypass and a per-register
// busy scoreboard. While the core is halted, a dump engine streams every
// register out over a valid/ready port.
// Ports:
//   clk, rst_b                 clock, asynchronous active-low reset
//   rd_num/rd_data/rd_busy     read addresses, data and busy bits (combinational)
//   wr_num/wr_data/wr_we       write ports
//   claim_num/claim_en         mark a register busy
//   halted                     core halted level, starts the dump
//   dump_valid/dump_ready      dump handshake
//   dump_idx/dump_data         current dump beat
//   dump_done                  all beats accepted
module regfile_mp #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned SIZE   = 32,
   parameter int unsigned NRD    = 2,
   parameter int unsigned NWR    = 1,
   parameter int unsigned BYPASS = 1
) (
   input  logic                         clk,
   input  logic                         rst_b,
   input  logic [NRD*$clog2(SIZE)-1:0]  rd_num,
   output logic [NRD*XLEN-1:0]          rd_data,
   output logic [NRD-1:0]               rd_busy,
   input  logic [NWR*$clog2(SIZE)-1:0]  wr_num,
   input  logic [NWR*XLEN-1:0]          wr_data,
   input  logic [NWR-1:0]               wr_we,
   input  logic [$clog2(SIZE)-1:0]      claim_num,
   input  logic                         claim_en,
   input  logic                         halted,
   output logic                         dump_valid,
   input  logic                         dump_ready,
   output logic [$clog2(SIZE)-1:0]      dump_idx,
   output logic [XLEN-1:0]              dump_data,
   output logic                         dump_done
);

   localparam int unsigned AW = $clog2(SIZE);

   typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     cnt, cnt_nxt;
   logic [XLEN-1:0]   regs [SIZE];
   logic [SIZE-1:0]   busy, busy_nxt;
   logic              wr_ok;

   // Writes and claims only act in IDLE so a dump sees a frozen snapshot.
   assign wr_ok = (state == S_IDLE);

   // Register array; later ports overwrite earlier ones, giving port NWR-1 priority.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int k = 0; k < int'(SIZE); k++) regs[k] <= '0;
      end else if (wr_ok) begin
         for (int p = 0; p < int'(NWR); p++) begin
            if (wr_we[p] && (wr_num[p*AW +: AW] != '0))
               regs[wr_num[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
         end
      end
   end

   // Scoreboard: writes clear, then a claim sets, so a same-cycle claim wins.
   always_comb begin
      busy_nxt = busy;
      if (wr_ok) begin
         for (int p = 0; p < int'(NWR); p++) begin
            if (wr_we[p]) busy_nxt[wr_num[p*AW +: AW]] = 1'b0;
         end
         if (claim_en) busy_nxt[claim_num] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) busy <= '0;
      else        busy <= busy_nxt;
   end

   // Read ports with optional forwarding of the winning same-cycle write.
   for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] val;

      assign addr = rd_num[g*AW +: AW];

      always_comb begin
         val = regs[addr];
         if ((BYPASS != 0) && wr_ok) begin
            for (int p = 0; p < int'(NWR); p++) begin
               if (wr_we[p] && (wr_num[p*AW +: AW] == addr))
                  val = wr_data[p*XLEN +: XLEN];
            end
         end
         if ((addr == '0) || !rst_b) val = '0;
      end

      assign rd_data[g*XLEN +: XLEN] = val;
      assign rd_busy[g]              = busy[addr];
   end

   // Dump FSM: state and counter register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Dump FSM: next state; dropping halted aborts a dump from any beat.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         S_IDLE: begin
            if (halted) begin
               state_nxt = S_DUMP;
               cnt_nxt   = '0;
            end
         end
         S_DUMP: begin
            if (!halted) begin
               state_nxt = S_IDLE;
            end else if (dump_ready) begin
               if (cnt == AW'(SIZE - 1)) state_nxt = S_DONE;
               else                      cnt_nxt   = cnt + AW'(1);
            end
         end
         S_DONE: begin
            if (!halted) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Dump FSM: outputs decoded from the registered state and counter.
   always_comb begin
      dump_valid = (state == S_DUMP);
      dump_done  = (state == S_DONE);
      dump_idx   = cnt;
      dump_data  = regs[cnt];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed bench for regfile_mp with a
// behavioural reference model. Two instances share all inputs: one with
// bypass enabled, one without.
module tb_regfile_mp;

   localparam int unsigned XLEN = 32;
   localparam int unsigned SIZE = 32;
   localparam int unsigned NRD  = 2;
   localparam int unsigned NWR  = 2;
   localparam int unsigned AW   = $clog2(SIZE);

   logic                 clk;
   logic                 rst_b;
   logic [NRD*AW-1:0]    rd_num;
   logic [NWR*AW-1:0]    wr_num;
   logic [NWR*XLEN-1:0]  wr_data;
   logic [NWR-1:0]       wr_we;
   logic [AW-1:0]        claim_num;
   logic                 claim_en;
   logic                 halted;
   logic                 dump_ready;

   logic [NRD*XLEN-1:0]  rd_data, rd_data_nb;
   logic [NRD-1:0]       rd_busy, rd_busy_nb;
   logic                 dump_valid, dump_valid_nb;
   logic [AW-1:0]        dump_idx, dump_idx_nb;
   logic [XLEN-1:0]      dump_data, dump_data_nb;
   logic                 dump_done, dump_done_nb;

   regfile_mp #(.XLEN(XLEN), .SIZE(SIZE), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
      .clk(clk), .rst_b(rst_b), .rd_num(rd_num), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_num(wr_num), .wr_data(wr_data), .wr_we(wr_we),
      .claim_num(claim_num), .claim_en(claim_en), .halted(halted),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
      .dump_data(dump_data), .dump_done(dump_done));

   regfile_mp #(.XLEN(XLEN), .SIZE(SIZE), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_b(rst_b), .rd_num(rd_num), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
      .wr_num(wr_num), .wr_data(wr_data), .wr_we(wr_we),
      .claim_num(claim_num), .claim_en(claim_en), .halted(halted),
      .dump_valid(dump_valid_nb), .dump_ready(dump_ready), .dump_idx(dump_idx_nb),
      .dump_data(dump_data_nb), .dump_done(dump_done_nb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: register contents, busy bits, dump progress.
   logic [XLEN-1:0] m_regs [SIZE];
   bit              m_busy [SIZE];
   int              m_mode;   // 0 = accepting writes, 1 = dumping, 2 = dump complete
   int              m_idx;
   int              beats [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < int'(SIZE); k++) begin
         m_regs[k] = '0;
         m_busy[k] = 1'b0;
      end
      m_mode = 0;
      m_idx  = 0;
   endtask

   function automatic int wnum(int p);
      return int'(wr_num[p*AW +: AW]);
   endfunction

   function automatic logic [XLEN-1:0] exp_rd(int a, bit byp);
      logic [XLEN-1:0] r;
      if (a == 0) return '0;
      r = m_regs[a];
      if (byp && m_mode == 0) begin
         for (int p = 0; p < int'(NWR); p++)
            if (wr_we[p] && wnum(p) == a) r = wr_data[p*XLEN +: XLEN];
      end
      return r;
   endfunction

   // Effect of one clock edge under the current inputs.
   task automatic model_edge();
      if (m_mode == 0) begin
         for (int p = 0; p < int'(NWR); p++) begin
            if (wr_we[p] && wnum(p) != 0) begin
               m_regs[wnum(p)] = wr_data[p*XLEN +: XLEN];
               m_busy[wnum(p)] = 1'b0;
            end
         end
         if (claim_en && claim_num != '0) m_busy[claim_num] = 1'b1;
         if (halted) begin
            m_mode = 1;
            m_idx  = 0;
         end
      end else if (m_mode == 1) begin
         if (!halted) m_mode = 0;
         else if (dump_ready) begin
            if (m_idx == int'(SIZE) - 1) m_mode = 2;
            else m_idx++;
         end
      end else if (!halted) begin
         m_mode = 0;
      end
   endtask

   task automatic check_all(input string tag);
      int a;
      for (int i = 0; i < int'(NRD); i++) begin
         a = int'(rd_num[i*AW +: AW]);
         chk($sformatf("%s.rd%0d_a%0d", tag, i, a), rd_data[i*XLEN +: XLEN], exp_rd(a, 1'b1));
         chk($sformatf("%s.rdnb%0d_a%0d", tag, i, a), rd_data_nb[i*XLEN +: XLEN], exp_rd(a, 1'b0));
         chk($sformatf("%s.busy%0d_a%0d", tag, i, a), 32'(rd_busy[i]), 32'(m_busy[a]));
         chk($sformatf("%s.busynb%0d_a%0d", tag, i, a), 32'(rd_busy_nb[i]), 32'(m_busy[a]));
      end
      chk({tag, ".valid"}, 32'(dump_valid), 32'(m_mode == 1));
      chk({tag, ".done"}, 32'(dump_done), 32'(m_mode == 2));
      chk({tag, ".validnb"}, 32'(dump_valid_nb), 32'(m_mode == 1));
      chk({tag, ".donenb"}, 32'(dump_done_nb), 32'(m_mode == 2));
      if (m_mode == 1) begin
         chk({tag, ".idx"}, 32'(dump_idx), 32'(m_idx));
         chk({tag, ".data"}, dump_data, m_regs[m_idx]);
         chk({tag, ".idxnb"}, 32'(dump_idx_nb), 32'(m_idx));
         chk({tag, ".datanb"}, dump_data_nb, m_regs[m_idx]);
      end
   endtask

   // One cycle: inputs were driven after a negedge; check, take the edge, return at next negedge.
   task automatic cycle(input string tag);
      #1;
      check_all(tag);
      if (dump_valid && dump_ready) beats.push_back(int'(dump_idx));
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      wr_we    = '0;
      claim_en = 1'b0;
   endtask

   task automatic rand_traffic(input int amax);
      wr_we     = NWR'($urandom);
      wr_num    = {AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax))};
      wr_data   = {32'($urandom), 32'($urandom)};
      claim_en  = 1'($urandom);
      claim_num = AW'($urandom_range(0, amax));
      rd_num    = {AW'($urandom_range(0, amax)), AW'($urandom_range(0, amax))};
   endtask

   task automatic check_beats(input string tag);
      chk({tag, ".count"}, 32'(beats.size()), 32'(SIZE));
      for (int k = 0; k < beats.size() && k < int'(SIZE); k++)
         chk($sformatf("%s.beat%0d", tag, k), 32'(beats[k]), 32'(k));
   endtask

   initial begin
      int n;
      rst_b = 1'b0; halted = 1'b0; dump_ready = 1'b0;
      rd_num = '0; wr_num = '0; wr_data = '0; claim_num = '0;
      idle_inputs();
      model_reset();
      rd_num = {AW'(9), AW'(3)};
      #2;
      check_all("reset");
      chk("reset.idx", 32'(dump_idx), 32'd0);
      @(negedge clk);
      rst_b = 1'b1;

      // All addresses read zero and not busy after reset.
      for (int a = 0; a < int'(SIZE) / 2; a++) begin
         rd_num = {AW'(a + int'(SIZE) / 2), AW'(a)};
         cycle("scan");
      end

      // r0 ignores writes.
      wr_we = 2'b01; wr_num = {AW'(0), AW'(0)}; wr_data = {32'h0, 32'hDEADBEEF};
      rd_num = {AW'(0), AW'(0)};
      cycle("r0w");
      idle_inputs();
      #1 chk("r0.read", rd_data[XLEN-1:0], 32'h0);
      cycle("r0r");

      // Both ports to r5: port 1 wins; bypass only on the bypass instance.
      wr_we = 2'b11; wr_num = {AW'(5), AW'(5)}; wr_data = {32'h22222222, 32'h11111111};
      rd_num = {AW'(5), AW'(5)};
      #1;
      chk("r5.bypass", rd_data[XLEN-1:0], 32'h22222222);
      chk("r5.nobypass", rd_data_nb[XLEN-1:0], 32'h0);
      cycle("r5w");
      idle_inputs();
      #1 chk("r5.stored", rd_data_nb[XLEN-1:0], 32'h22222222);
      cycle("r5r");

      // Scoreboard on r7.
      rd_num = {AW'(7), AW'(7)};
      claim_en = 1'b1; claim_num = AW'(7);
      cycle("claim");
      idle_inputs();
      #1 chk("r7.busy_set", 32'(rd_busy[0]), 32'd1);
      cycle("claimed");
      wr_we = 2'b01; wr_num = {AW'(0), AW'(7)}; wr_data = {32'h0, 32'h77};
      cycle("clear");
      idle_inputs();
      #1 chk("r7.busy_clr", 32'(rd_busy[0]), 32'd0);
      cycle("cleared");
      wr_we = 2'b10; wr_num = {AW'(7), AW'(1)}; claim_en = 1'b1; claim_num = AW'(7);
      cycle("both");
      idle_inputs();
      #1 chk("r7.claim_wins", 32'(rd_busy[1]), 32'd1);
      cycle("bothr");

      // Random traffic with frequent address collisions.
      for (int t = 0; t < 300; t++) begin
         rand_traffic((t % 3 == 0) ? int'(SIZE) - 1 : 7);
         cycle("rnd");
      end
      idle_inputs();

      // Load rN = N*0x01010101.
      for (int k = 0; k < int'(SIZE) / 2; k++) begin
         n = 2 * k;
         wr_we   = 2'b11;
         wr_num  = {AW'(n + 1), AW'(n)};
         wr_data = {32'(n + 1) * 32'h01010101, 32'(n) * 32'h01010101};
         cycle("load");
      end
      idle_inputs();
      rd_num = {AW'(31), AW'(2)};
      #1 chk("load.r31", rd_data[2*XLEN-1:XLEN], 32'h1F1F1F1F);

      // Full dump with ready held high.
      beats.delete();
      halted = 1'b1; dump_ready = 1'b1;
      n = 0;
      while (m_mode != 2 && n < 100) begin cycle("dump1"); n++; end
      chk("dump1.cycles", 32'(n), 32'(SIZE + 1));
      check_beats("dump1");
      cycle("done1");
      halted = 1'b0;
      cycle("exit1");
      cycle("idle1");

      // Aborted dump restarts from zero.
      halted = 1'b1;
      for (int t = 0; t < 5; t++) cycle("abort");
      halted = 1'b0;
      cycle("abort_drop");

      // Stalled dump with writes/claims attempted throughout.
      beats.delete();
      halted = 1'b1;
      n = 0;
      while (m_mode != 2 && n < 200) begin
         dump_ready = 1'(n % 2);
         rand_traffic(int'(SIZE) - 1);
         cycle("dump2");
         n++;
      end
      chk("dump2.finished", 32'(m_mode), 32'd2);
      check_beats("dump2");
      idle_inputs();
      halted = 1'b0;
      cycle("exit2");

      // Reset at beat 10 aborts at once.
      beats.delete();
      halted = 1'b1; dump_ready = 1'b1;
      n = 0;
      while (beats.size() < 10 && n < 50) begin cycle("dump3"); n++; end
      chk("dump3.beats", 32'(beats.size()), 32'd10);
      rst_b = 1'b0;
      #1;
      model_reset();
      chk("rst3.valid", 32'(dump_valid), 32'd0);
      chk("rst3.idx", 32'(dump_idx), 32'd0);
      chk("rst3.rd", rd_data[2*XLEN-1:XLEN], 32'h0);
      check_all("rst3");
      @(negedge clk);
      rst_b = 1'b1;

      // Re-halt dumps all zeros from index 0.
      beats.delete();
      n = 0;
      while (m_mode != 2 && n < 100) begin cycle("dump4"); n++; end
      check_beats("dump4");
      halted = 1'b0;
      cycle("exit4");
      cycle("idle4");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
